// File: rtl/ring_tdm_mux_if.sv
// ring_tdm_mux_if: phase/channel inputs and serialised outputs of ring_tdm_mux
//   master: drives phase, ch_data, ch_valid, err_clr; observes the outputs
//   slave : the multiplexer itself
interface ring_tdm_mux_if #(
    parameter int WIDTH = 4,
    parameter int DW    = 8
);
    logic [WIDTH-1:0]          phase;
    logic [WIDTH*DW-1:0]       ch_data;
    logic [WIDTH-1:0]          ch_valid;
    logic                      err_clr;
    logic [DW-1:0]             out_data;
    logic [$clog2(WIDTH)-1:0]  out_ch;
    logic                      out_valid;
    logic                      frame_start;
    logic                      locked;
    logic                      err_sticky;
    logic [7:0]                err_count;

    modport master (
        output phase, ch_data, ch_valid, err_clr,
        input  out_data, out_ch, out_valid, frame_start, locked, err_sticky, err_count
    );

    modport slave (
        input  phase, ch_data, ch_valid, err_clr,
        output out_data, out_ch, out_valid, frame_start, locked, err_sticky, err_count
    );
endinterface

// File: rtl/ring_tdm_mux.sv
// ring_tdm_mux: one-hot phase driven TDM serialiser with lock FSM and phase error counter
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   bus     : ring_tdm_mux_if.slave (phase, ch_data, ch_valid, err_clr in;
//             out_data, out_ch, out_valid, frame_start, locked, err_sticky, err_count out)
//   RING_TDM_ROT_CHECK_EN: when defined, phase must also rotate left by one each cycle
module ring_tdm_mux #(
    parameter int WIDTH    = 4,
    parameter int DW       = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    ring_tdm_mux_if.slave      bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t          state, state_n;
    logic [7:0]      lock_cnt, lock_cnt_n;
    logic [IW-1:0]   idx;
    logic            onehot, rot_ok, good, valid_n;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_ch;
    logic            out_valid, frame_start, err_sticky;
    logic [7:0]      err_count;

`ifdef RING_TDM_ROT_CHECK_EN
    logic [WIDTH-1:0] prev_phase;
    logic             prev_ok;

    // The rotation check is skipped after a non-one-hot sample so the ring can relock.
    assign rot_ok = !prev_ok || bus.phase == {prev_phase[WIDTH-2:0], prev_phase[WIDTH-1]};

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            prev_phase <= '0;
            prev_ok    <= 1'b0;
        end else begin
            prev_phase <= bus.phase;
            prev_ok    <= onehot;
        end
`else
    assign rot_ok = 1'b1;
`endif

    assign onehot  = $onehot(bus.phase);
    assign good    = onehot && rot_ok;
    assign valid_n = state == LOCKED && good && bus.ch_valid[idx];

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (bus.phase[i]) idx = IW'(i);
    end

    always_comb begin
        state_n    = state;
        lock_cnt_n = lock_cnt;
        if (!good) begin
            state_n    = UNLOCKED;
            lock_cnt_n = '0;
        end else if (state == UNLOCKED) begin
            state_n    = lock_cnt == 8'(LOCK_CNT - 1) ? LOCKED : UNLOCKED;
            lock_cnt_n = lock_cnt == 8'(LOCK_CNT - 1) ? 8'd0 : lock_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_cnt_n;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out_data    <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            err_sticky  <= 1'b0;
            err_count   <= '0;
        end else begin
            out_valid   <= valid_n;
            frame_start <= valid_n && idx == '0;
            if (good) begin
                out_data <= bus.ch_data[idx*DW +: DW];
                out_ch   <= idx;
            end
            // A bad sample outranks a simultaneous clear: the new error is kept.
            if (!good) begin
                err_sticky <= 1'b1;
                err_count  <= bus.err_clr ? 8'd1 : err_count + 8'(err_count != 8'hff);
            end else if (bus.err_clr) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end
        end

    assign bus.out_data    = out_data;
    assign bus.out_ch      = out_ch;
    assign bus.out_valid   = out_valid;
    assign bus.frame_start = frame_start;
    assign bus.locked      = state == LOCKED;
    assign bus.err_sticky  = err_sticky;
    assign bus.err_count   = err_count;
endmodule
